// File: rtl/calc_key_sequencer.sv
// Keypad sequencer for a combinational calculator: collects hex operands and an
// operation code, waits for the result to settle, then hands it to a consumer.
module calc_key_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [1:0]  key_kind,
  input  logic [4:0]  key_val,
  output logic [15:0] inp1,
  output logic [15:0] inp2,
  output logic [4:0]  select,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_a,
  output logic [15:0] res_b,
  output logic        err
);

  typedef enum logic [1:0] {ENTRY_A, ENTRY_B, EXEC, RESULT} state_t;

  localparam logic [1:0] KIND_DIGIT = 2'b00;
  localparam logic [1:0] KIND_OP    = 2'b01;
  localparam logic [1:0] KIND_EQ    = 2'b10;
  localparam logic [1:0] KIND_CLEAR = 2'b11;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_r, state_s;
  logic [15:0] inp1_r, inp1_s;
  logic [15:0] inp2_r, inp2_s;
  logic [4:0]  select_r, select_s;
  logic [15:0] res_a_r, res_a_s;
  logic [15:0] res_b_r, res_b_s;
  logic        res_valid_r, res_valid_s;
  logic        fresh_r, fresh_s;
  logic        err_r, err_s;
  logic [3:0]  cnt_r, cnt_s;

  function automatic logic is_unary(input logic [4:0] code);
    return (code == 5'd7) || ((code >= 5'd12) && (code <= 5'd18));
  endfunction

  // Operator code 19 behaves exactly like the dedicated clear key.
  function automatic logic is_clear(input logic [1:0] kind, input logic [4:0] code);
    return (kind == KIND_CLEAR) || ((kind == KIND_OP) && (code == 5'd19));
  endfunction

  // Next-state and datapath update for key entry, settling and result handoff
  always_comb begin
    state_s     = state_r;
    inp1_s      = inp1_r;
    inp2_s      = inp2_r;
    select_s    = select_r;
    res_a_s     = res_a_r;
    res_b_s     = res_b_r;
    res_valid_s = res_valid_r;
    fresh_s     = fresh_r;
    cnt_s       = cnt_r;
    err_s       = 1'b0;
    case (state_r)
      ENTRY_A, ENTRY_B: begin
        if (!key_valid) begin
          state_s = state_r;
        end else if (is_clear(key_kind, key_val)) begin
          inp1_s   = 16'h0000;
          inp2_s   = 16'h0000;
          select_s = 5'd0;
          fresh_s  = 1'b0;
          state_s  = ENTRY_A;
        end else begin
          case (key_kind)
            KIND_DIGIT: begin
              if (state_r == ENTRY_B) begin
                inp2_s = {inp2_r[11:0], key_val[3:0]};
              end else if (fresh_r) begin
                // First digit after a chained result starts a new operand.
                inp1_s  = {12'h000, key_val[3:0]};
                fresh_s = 1'b0;
              end else begin
                inp1_s = {inp1_r[11:0], key_val[3:0]};
              end
            end
            KIND_OP: begin
              if (key_val >= 5'd20) begin
                err_s = 1'b1;
              end else begin
                select_s = key_val;
                if (is_unary(key_val)) begin
                  inp2_s  = 16'h0000;
                  cnt_s   = 4'd0;
                  state_s = EXEC;
                end else if (state_r == ENTRY_A) begin
                  inp2_s  = 16'h0000;
                  fresh_s = 1'b0;
                  state_s = ENTRY_B;
                end else begin
                  state_s = ENTRY_B;
                end
              end
            end
            KIND_EQ: begin
              if (state_r == ENTRY_B) begin
                cnt_s   = 4'd0;
                state_s = EXEC;
              end else begin
                state_s = state_r;
              end
            end
            default: state_s = ENTRY_A;
          endcase
        end
      end
      EXEC: begin
        if (cnt_r == SETTLE_LAST) begin
          res_a_s     = a;
          res_b_s     = b;
          res_valid_s = 1'b1;
          cnt_s       = 4'd0;
          state_s     = RESULT;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_s = 1'b0;
          inp1_s      = res_a_r;
          inp2_s      = 16'h0000;
          fresh_s     = 1'b1;
          state_s     = ENTRY_A;
        end else begin
          state_s = RESULT;
        end
      end
      default: state_s = ENTRY_A;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ENTRY_A;
      inp1_r      <= 16'h0000;
      inp2_r      <= 16'h0000;
      select_r    <= 5'd0;
      res_a_r     <= 16'h0000;
      res_b_r     <= 16'h0000;
      res_valid_r <= 1'b0;
      fresh_r     <= 1'b0;
      err_r       <= 1'b0;
      cnt_r       <= 4'd0;
    end else begin
      state_r     <= state_s;
      inp1_r      <= inp1_s;
      inp2_r      <= inp2_s;
      select_r    <= select_s;
      res_a_r     <= res_a_s;
      res_b_r     <= res_b_s;
      res_valid_r <= res_valid_s;
      fresh_r     <= fresh_s;
      err_r       <= err_s;
      cnt_r       <= cnt_s;
    end
  end

  assign key_ready = (state_r == ENTRY_A) || (state_r == ENTRY_B);
  assign inp1      = inp1_r;
  assign inp2      = inp2_r;
  assign select    = select_r;
  assign res_valid = res_valid_r;
  assign res_a     = res_a_r;
  assign res_b     = res_b_r;
  assign err       = err_r;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Scoreboard bench for calc_key_sequencer: a behavioural calculator drives a/b,
// a key-level reference model predicts operands and results.
module tb_calc_key_sequencer;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [1:0]  key_kind = 2'd0;
  logic [4:0]  key_val = 5'd0;
  logic [15:0] inp1, inp2, a, b, res_a, res_b;
  logic [4:0]  select;
  logic        res_valid, err;
  logic        res_ready = 1'b0;

  always #5 clk = ~clk;

  calc_key_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_kind(key_kind), .key_val(key_val), .inp1(inp1), .inp2(inp2),
    .select(select), .a(a), .b(b), .res_valid(res_valid), .res_ready(res_ready),
    .res_a(res_a), .res_b(res_b), .err(err)
  );

  // Behavioural calculator: returns {a, b}
  function automatic logic [31:0] calc(input logic [4:0] s, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] ra, rb;
    logic [31:0] p;
    ra = 16'h0000;
    rb = 16'h0000;
    p  = {16'h0000, x} * {16'h0000, y};
    case (s)
      5'd0:  ra = x + y;
      5'd1:  ra = x - y;
      5'd2:  begin ra = p[15:0]; rb = p[31:16]; end
      5'd3:  if (y == 16'h0000) begin ra = 16'hFFFF; rb = x; end
             else begin ra = x / y; rb = x % y; end
      5'd4:  ra = x & y;
      5'd5:  ra = x | y;
      5'd6:  ra = x ^ y;
      5'd7:  ra = ~x;
      5'd8:  ra = x << y[3:0];
      5'd9:  ra = x >> y[3:0];
      5'd10: ra = (x > y) ? x : y;
      5'd11: ra = (x < y) ? x : y;
      5'd12: ra = -x;
      5'd13: ra = x + 16'd1;
      5'd14: ra = x - 16'd1;
      5'd15: ra = {x[7:0], x[15:8]};
      5'd16: ra = x << 1;
      5'd17: ra = x >> 1;
      5'd18: ra = 16'($countones(x));
      default: ra = x;
    endcase
    return {ra, rb};
  endfunction

  always_comb {a, b} = calc(select, inp1, inp2);

  typedef struct {
    logic [15:0] ea;
    logic [15:0] eb;
    int          due;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: key-level view of the sequencer
  logic [15:0] m_inp1, m_inp2, m_last_a, m_last_b;
  logic [4:0]  m_sel;
  bit          m_fresh, m_second, m_busy, m_have_res, m_err;
  int          m_due;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_inp1 = 16'h0; m_inp2 = 16'h0; m_sel = 5'd0; m_fresh = 1'b0; m_second = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_busy = 1'b0; m_have_res = 1'b0; m_err = 1'b0; m_last_a = 16'h0; m_last_b = 16'h0;
    m_due = 0;
    q.delete();
  endtask

  task automatic start_exec();
    logic [31:0] r;
    r = calc(m_sel, m_inp1, m_inp2);
    m_busy = 1'b1; m_second = 1'b0; m_due = cyc + S;
    q.push_back('{r[31:16], r[15:0], m_due});
  endtask

  task automatic cycle(input bit kv, input logic [1:0] kk, input logic [4:0] kvv, input bit rr);
    key_valid = kv; key_kind = kk; key_val = kvv; res_ready = rr;
    @(posedge clk);
    cyc++;
    m_err = 1'b0;
    if (m_have_res && rr) begin
      m_inp1 = m_last_a; m_inp2 = 16'h0; m_fresh = 1'b1;
      m_busy = 1'b0; m_have_res = 1'b0;
    end else if (kv && !m_busy) begin
      case (kk)
        2'd0: begin
          if (m_second) m_inp2 = {m_inp2[11:0], kvv[3:0]};
          else if (m_fresh) begin m_inp1 = {12'h000, kvv[3:0]}; m_fresh = 1'b0; end
          else m_inp1 = {m_inp1[11:0], kvv[3:0]};
        end
        2'd1: begin
          if (kvv == 5'd19) model_clear();
          else if (kvv >= 5'd20) m_err = 1'b1;
          else begin
            m_sel = kvv;
            if (kvv inside {5'd7, [5'd12:5'd18]}) begin m_inp2 = 16'h0; start_exec(); end
            else begin
              if (!m_second) begin m_inp2 = 16'h0; m_fresh = 1'b0; end
              m_second = 1'b1;
            end
          end
        end
        2'd2: if (m_second) start_exec();
        default: model_clear();
      endcase
    end
    if (m_busy && !m_have_res && cyc == m_due) begin
      m_have_res = 1'b1;
      m_last_a = q[$].ea;
      m_last_b = q[$].eb;
    end
    #1;
    chk("key_ready", key_ready, !m_busy);
    chk("res_valid", res_valid, m_have_res);
    chk("inp1", inp1, m_inp1);
    chk("inp2", inp2, m_inp2);
    chk("select", select, m_sel);
    chk("err", err, m_err);
    if (m_have_res) begin
      chk("res_a_hold", res_a, m_last_a);
      chk("res_b_hold", res_b, m_last_b);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_key_ready", key_ready, 1);
    chk("rst_inp1", inp1, 0);
    chk("rst_inp2", inp2, 0);
    chk("rst_select", select, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_a", res_a, 0);
    chk("rst_res_b", res_b, 0);
    chk("rst_err", err, 0);
  endtask

  // Monitor: pops the expected result whenever res_valid rises
  initial begin
    bit prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (res_valid && !prev) begin
        if (q.size() == 0) begin
          chk("res_valid_unexpected", res_valid, 0);
        end else begin
          e = q.pop_front();
          chk("res_a", res_a, e.ea);
          chk("res_b", res_b, e.eb);
          chk("res_latency", cyc, e.due);
        end
      end
      prev = res_valid;
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // digit1 digit2 op0 digit3 digit4 equals
    cycle(1, 2'd0, 5'd1, 0); cycle(1, 2'd0, 5'd2, 0); cycle(1, 2'd1, 5'd0, 0);
    cycle(1, 2'd0, 5'd3, 0); cycle(1, 2'd0, 5'd4, 0); cycle(1, 2'd2, 5'd0, 0);
    chk("d_inp1_0012", inp1, 16'h0012);
    chk("d_inp2_0034", inp2, 16'h0034);
    chk("d_exec_key_ready", key_ready, 0);
    cycle(0, 2'd0, 5'd0, 0);
    chk("d_res_valid_early", res_valid, 0);
    cycle(0, 2'd0, 5'd0, 0);
    chk("d_res_valid", res_valid, 1);
    chk("d_res_a_0046", res_a, 16'h0046);

    // Back-pressure on the result while keys are offered
    for (int i = 0; i < 5; i++) begin
      cycle(1, 2'd0, 5'd9, 0);
      chk("bp_res_a", res_a, 16'h0046);
      chk("bp_inp1", inp1, 16'h0012);
    end
    cycle(0, 2'd0, 5'd0, 1);
    chk("hs_res_valid", res_valid, 0);
    chk("hs_inp1_chain", inp1, 16'h0046);
    chk("hs_res_a_held", res_a, 16'h0046);
    cycle(1, 2'd0, 5'd7, 0);
    chk("fresh_digit", inp1, 16'h0007);

    // Rebuild the 0x0046 result, then chain an operator instead of a digit
    cycle(1, 2'd3, 5'd0, 0);
    cycle(1, 2'd0, 5'd1, 0); cycle(1, 2'd0, 5'd2, 0); cycle(1, 2'd1, 5'd0, 0);
    cycle(1, 2'd0, 5'd3, 0); cycle(1, 2'd0, 5'd4, 0); cycle(1, 2'd2, 5'd0, 0);
    cycle(0, 2'd0, 5'd0, 0); cycle(0, 2'd0, 5'd0, 0); cycle(0, 2'd0, 5'd0, 1);
    cycle(1, 2'd1, 5'd1, 0);
    chk("chain_select", select, 5'd1);
    chk("chain_inp1", inp1, 16'h0046);

    // Illegal operator then op-code clear in ENTRY_B
    cycle(1, 2'd0, 5'd5, 0);
    cycle(1, 2'd1, 5'b10110, 0);
    chk("illegal_err", err, 1);
    chk("illegal_inp2", inp2, 16'h0005);
    cycle(0, 2'd0, 5'd0, 0);
    chk("illegal_err_pulse", err, 0);
    cycle(1, 2'd0, 5'd6, 0);
    chk("illegal_still_b", inp2, 16'h0056);
    cycle(1, 2'd1, 5'b10011, 0);
    chk("opclr_inp1", inp1, 16'h0000);
    chk("opclr_select", select, 5'd0);

    // Top nibble discard and unary operator straight to EXEC
    for (int d = 1; d <= 5; d++) cycle(1, 2'd0, 5'(d), 0);
    chk("shift_2345", inp1, 16'h2345);
    cycle(1, 2'd1, 5'd7, 0);
    chk("unary_key_ready", key_ready, 0);
    chk("unary_select", select, 5'd7);
    cycle(0, 2'd0, 5'd0, 0); cycle(0, 2'd0, 5'd0, 0);
    chk("unary_res_a", res_a, 16'hDCBA);
    cycle(0, 2'd0, 5'd0, 1);

    // Reset during the first EXEC cycle
    cycle(1, 2'd0, 5'd1, 0); cycle(1, 2'd1, 5'd0, 0); cycle(1, 2'd0, 5'd2, 0);
    cycle(1, 2'd2, 5'd0, 0);
    key_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(0, 2'd0, 5'd0, 1);
    chk("post_rst_res_valid", res_valid, 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [1:0] kk;
      logic [4:0] vv;
      r = $urandom_range(0, 99);
      kk = (r < 50) ? 2'd0 : (r < 78) ? 2'd1 : (r < 93) ? 2'd2 : 2'd3;
      if (kk == 2'd1)
        vv = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 18)) : 5'($urandom_range(19, 31));
      else
        vv = 5'($urandom_range(0, 31));
      cycle($urandom_range(0, 9) < 6, kk, vv, $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < S + 3; i++) cycle(0, 2'd0, 5'd0, 1);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_key_sequencer.md
CALC_KEY_SEQUENCER -- requirements
Module: calc_key_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, number of clock cycles operands/select are held stable before the calculator result is captured (legal 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port key_valid  input  1  key entry present.
REQ-005 SHALL have port key_ready  output  1  key entry can be accepted.
REQ-006 SHALL have port key_kind  input  2  00 digit, 01 operator, 10 equals, 11 clear.
REQ-007 SHALL have port key_val  input  5  digit: hex digit in [3:0]; operator: calculator select code.
REQ-008 SHALL have port inp1  output  16  operand 1 to calculator.
REQ-009 SHALL have port inp2  output  16  operand 2 to calculator.
REQ-010 SHALL have port select  output  5  operation code to calculator.
REQ-011 SHALL have port a  input  16  calculator primary result.
REQ-012 SHALL have port b  input  16  calculator secondary result (remainder/fraction).
REQ-013 SHALL have port res_valid  output  1  captured result available.
REQ-014 SHALL have port res_ready  input  1  result consumer ready.
REQ-015 SHALL have ports res_a, res_b  output  16 each  captured a and b.
REQ-016 SHALL have port err  output  1  one-cycle pulse on illegal operator code.

Function
REQ-017 States SHALL be ENTRY_A (reset state), ENTRY_B, EXEC, RESULT; a key is accepted only on a cycle with key_valid && key_ready.
REQ-018 key_ready SHALL be decoded from state: 1 in ENTRY_A/ENTRY_B, 0 in EXEC/RESULT; keys offered while key_ready=0 have no effect.
REQ-019 Digit in ENTRY_A SHALL set inp1 <= {inp1[11:0], digit}; in ENTRY_B, inp2 <= {inp2[11:0], digit}; the top nibble is discarded (no saturation, no flag).
REQ-020 When the fresh flag is set (after a consumed result), the first digit in ENTRY_A SHALL load inp1 <= {12'h000, digit} and clear fresh.
REQ-021 Binary operator code (0-6, 8-11) in ENTRY_A SHALL latch select, clear inp2 to 0, clear fresh, go to ENTRY_B.
REQ-022 Unary operator code (7, 12-18) in ENTRY_A SHALL latch select, force inp2 to 0, go directly to EXEC.
REQ-023 Operator in ENTRY_B SHALL replace select (binary code: stay in ENTRY_B, inp2 kept; unary code: go to EXEC with inp2 forced to 0).
REQ-024 Operator code 19 in any accepting state SHALL act as clear; codes 20-31 SHALL be accepted, pulse err for exactly one cycle, change nothing else.
REQ-025 Equals in ENTRY_B SHALL go to EXEC; equals in ENTRY_A SHALL be accepted with no effect.
REQ-026 Clear key SHALL zero inp1, inp2, select, clear fresh, and go to ENTRY_A.
REQ-027 inp1, inp2, select SHALL be registered and SHALL NOT change while in EXEC or RESULT.
REQ-028 EXEC SHALL count SETTLE_CYCLES cycles; on the clock edge ending the last EXEC cycle, res_a <= a, res_b <= b, res_valid <= 1, state RESULT.
REQ-029 Latency: key accepted at edge T enters EXEC in cycle T+1; res_valid SHALL be first high in cycle T+1+SETTLE_CYCLES.
REQ-030 In RESULT, res_valid/res_a/res_b SHALL hold until res_valid && res_ready; on that edge res_valid <= 0, inp1 <= res_a, inp2 <= 0, fresh <= 1, state ENTRY_A.
REQ-031 res_a/res_b SHALL hold last captured values after handshake until the next capture.

Reset
REQ-032 rst_n low SHALL immediately force state ENTRY_A and inp1, inp2, select, res_a, res_b, res_valid, err, fresh, settle counter to 0, including mid-EXEC or mid-RESULT; key_ready reads 1 during and after reset.
REQ-033 First key SHALL be acceptable on the first rising edge after rst_n deasserts.

Verification
REQ-034 SETTLE_CYCLES=2, behavioural calculator model: keys digit1, digit2, op 00000, digit3, digit4, equals -> inp1=0x0012, inp2=0x0034, select=0, res_a=0x0046, res_valid first high 3 cycles after equals accepted.
REQ-035 Keys 1,2,3,4,5 in ENTRY_A -> inp1=0x2345; then op 00111 -> EXEC immediately, inp2=0, res_a=0xDCBA.
REQ-036 res_ready held 0 for 5 cycles in RESULT while keys offered -> res_valid and res_a stable, key_ready=0, inp1/inp2/select unchanged; res_ready=1 -> res_valid 0 next cycle, inp1=previous res_a.
REQ-037 After chained result 0x0046, digit 7 -> inp1=0x0007; op 00001 instead -> select=1, inp1 stays 0x0046.
REQ-038 Operator key_val=5'b10110 in ENTRY_B -> err high exactly one cycle, state/inp2/select unchanged; key_val=5'b10011 -> all operands zero, ENTRY_A.
REQ-039 rst_n asserted during cycle 1 of EXEC -> all outputs 0 immediately, no res_valid after release, key_ready=1.
